dmux_nway_reg: RTL and testbench

Registered, parametrised N-way demultiplexer with per-channel valid/ready handshakes. It accepts one data word per cycle on a single input stream and steers it to one selected output channel, or to all channels in broadcast mode. Each output channel has a one-entry holding register. The block sits between a single producer (for example the CPU's memory-mapped write path) and several independent consumers that can each apply backpressure.

---
 rtl/dmux_nway_reg.sv | 117 +++++++++++
 tb/tb_dmux_nway_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_nway_reg.sv
// Registered N-way demultiplexer: one input stream steered to a selected channel
// (or broadcast to all), each channel holding one word behind its own valid/ready.
module dmux_nway_reg #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [7:0]                drop_count
);

    // Handshake: a word moves on any rising edge where valid and ready are both
    // high; in_ready never looks at in_valid, and out_valid never looks at out_ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    ch_state_e                 state_q [CHANNELS];
    ch_state_e                 state_d [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] data_q;
    logic [CHANNELS*WIDTH-1:0] data_d;
    logic [7:0]                drop_q;
    logic [7:0]                drop_d;

    logic [CHANNELS-1:0] sel_hot;
    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                xfer;
    logic                drop;

    // One-hot decode doubles as the range check, so non-power-of-two counts need no compare.
    always_comb begin
        sel_hot = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sel_hot[k] = (in_sel == SEL_W'(k));
        end
    end

    always_comb begin
        sel_ok = |sel_hot;
        free   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            free[k] = (state_q[k] == EMPTY) | out_ready[k];
        end
    end

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_ok) begin
            in_ready = |(sel_hot & free);
        end
    end

    always_comb begin
        xfer = in_valid & in_ready;
        load = '0;
        if (xfer) begin
            load = in_bcast ? {CHANNELS{1'b1}} : sel_hot;
        end
        drop = xfer & ~in_bcast & ~sel_ok;
    end

    always_comb begin
        data_d = data_q;
        for (int k = 0; k < CHANNELS; k++) begin
            state_d[k] = state_q[k];
            if (load[k]) begin
                state_d[k]                = FULL;
                data_d[k*WIDTH +: WIDTH]  = in_data;
            end else if ((state_q[k] == FULL) && out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
        drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= EMPTY;
            end
            data_q <= '0;
            drop_q <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= state_d[k];
            end
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    // out_valid is the per-channel state itself, so it doubles as the FSM debug view.
    always_comb begin
        out_valid = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            out_valid[k] = (state_q[k] == FULL);
        end
    end

    assign out_data   = data_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_dmux_nway_reg.sv
// Directed bench for dmux_nway_reg: an 8-channel instance with per-channel
// scoreboard queues, and a 6-channel instance for out-of-range drops.
module tb_dmux_nway_reg;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic         v8, ir8, bc8;
  logic [W-1:0] d8;
  logic [2:0]   sel8;
  logic [7:0]   ov8, or8, dc8;
  logic [8*W-1:0] od8;

  logic         v6, ir6, bc6;
  logic [W-1:0] d6;
  logic [2:0]   sel6;
  logic [5:0]   ov6, or6;
  logic [7:0]   dc6;
  logic [6*W-1:0] od6;

  logic [W-1:0] exp_q [8][$];
  int checks = 0;
  int errors = 0;
  int exp_drop;

  dmux_nway_reg #(.WIDTH(W), .CHANNELS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_data(d8),
    .in_sel(sel8), .in_bcast(bc8), .out_valid(ov8), .out_ready(or8),
    .out_data(od8), .drop_count(dc8)
  );

  dmux_nway_reg #(.WIDTH(W), .CHANNELS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(v6), .in_ready(ir6), .in_data(d6),
    .in_sel(sel6), .in_bcast(bc6), .out_valid(ov6), .out_ready(or6),
    .out_data(od6), .drop_count(dc6)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] lane8(input int k);
    return od8[k*W +: W];
  endfunction

  // driver tasks: called just after a rising edge, return just after the next one
  task automatic send8(input int sel, input bit bc, input logic [W-1:0] d,
                       input bit exp_rdy, input string nm);
    v8 = 1'b1; sel8 = 3'(sel); bc8 = bc; d8 = d;
    @(negedge clk);
    check(nm, {31'b0, ir8}, {31'b0, exp_rdy});
    if (exp_rdy) begin
      if (bc) begin
        for (int k = 0; k < 8; k++) exp_q[k].push_back(d);
      end else begin
        exp_q[sel].push_back(d);
      end
    end
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send6(input logic [2:0] sel, input logic [W-1:0] d, input string nm);
    v6 = 1'b1; sel6 = sel; d6 = d;
    @(negedge clk);
    check({nm, "_rdy"}, {31'b0, ir6}, 32'd1);
    check({nm, "_ovalid"}, {26'b0, ov6}, 32'd0);
    @(posedge clk); #1;
    v6 = 1'b0;
  endtask

  // scoreboard monitor: a handshake visible before the edge completes on that edge
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (ov8[k] && or8[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_ch%0d: got word 0x%0h expected none", k, lane8(k));
          end else begin
            check($sformatf("mon_ch%0d", k), {16'b0, lane8(k)}, {16'b0, exp_q[k].pop_front()});
          end
        end
      end
    end
  end

  initial begin
    v8 = 0; bc8 = 0; d8 = '0; sel8 = '0; or8 = '0;
    v6 = 0; bc6 = 0; d6 = '0; sel6 = '0; or6 = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ovalid", {24'b0, ov8}, 32'h0);
    check("rst_data", {31'b0, (od8 == '0)}, 32'd1);
    check("rst_drop8", {24'b0, dc8}, 32'h0);
    check("rst_drop6", {24'b0, dc6}, 32'h0);
    check("rst_inready", {31'b0, ir8}, 32'd1);
    #14 rst_n = 1'b1;
    @(posedge clk); #1;

    // unicast
    send8(5, 0, 16'hA5A5, 1, "uni_rdy");
    check("uni_ovalid", {24'b0, ov8}, 32'h20);
    check("uni_lane5", {16'b0, lane8(5)}, 32'hA5A5);
    sel8 = 3'd5; #1;
    check("uni_busy_rdy", {31'b0, ir8}, 32'd0);
    sel8 = 3'd2; #1;
    check("uni_other_rdy", {31'b0, ir8}, 32'd1);
    or8 = 8'h20;
    idle(1);
    or8 = 8'h00;
    check("uni_drained", {24'b0, ov8}, 32'h0);
    check("uni_lane_kept", {16'b0, lane8(5)}, 32'hA5A5);

    // backpressure then back-to-back stream on channel 3
    send8(3, 0, 16'h0001, 1, "hold_first");
    for (int i = 0; i < 3; i++) begin
      send8(3, 0, 16'h0001, 0, "hold_rdy");
      check("hold_lane3", {16'b0, lane8(3)}, 32'h0001);
      check("hold_ovalid", {24'b0, ov8}, 32'h08);
    end
    or8 = 8'h08;
    for (int d = 2; d <= 5; d++) begin
      send8(3, 0, 16'(d), 1, "stream_rdy");
      check("stream_ovalid", {24'b0, ov8}, 32'h08);
      check("stream_lane3", {16'b0, lane8(3)}, 32'(d));
    end
    idle(1);
    or8 = 8'h00;
    check("stream_done", {24'b0, ov8}, 32'h0);

    // broadcast blocked by one busy channel, then all-or-nothing success
    send8(6, 0, 16'h0666, 1, "bpre_rdy");
    send8(0, 1, 16'hBEEF, 0, "bcast_blocked");
    check("bblk_ovalid", {24'b0, ov8}, 32'h40);
    check("bblk_lane6", {16'b0, lane8(6)}, 32'h0666);
    check("bblk_lane0", {16'b0, lane8(0)}, 32'h0000);
    check("bblk_lane5", {16'b0, lane8(5)}, 32'hA5A5);
    or8 = 8'h40;
    send8(0, 1, 16'hBEEF, 1, "bcast_rdy");
    or8 = 8'h00;
    check("bcast_ovalid", {24'b0, ov8}, 32'hFF);
    for (int k = 0; k < 8; k++) check($sformatf("bcast_lane%0d", k), {16'b0, lane8(k)}, 32'hBEEF);
    or8 = 8'hFF;
    idle(1);
    or8 = 8'h00;
    check("bcast_drained", {24'b0, ov8}, 32'h0);

    // drain and refill in one cycle; independent channel not blocked
    send8(0, 0, 16'h1111, 1, "dr_fill");
    send8(1, 0, 16'h3333, 1, "indep_rdy");
    check("indep_ovalid", {24'b0, ov8}, 32'h03);
    or8 = 8'h01;
    send8(0, 0, 16'h2222, 1, "drain_refill_rdy");
    or8 = 8'h00;
    check("refill_ovalid", {24'b0, ov8}, 32'h03);
    check("refill_lane0", {16'b0, lane8(0)}, 32'h2222);
    or8 = 8'h03;
    idle(1);
    or8 = 8'h00;
    check("refill_drained", {24'b0, ov8}, 32'h0);

    // out-of-range selects on the 6-channel instance
    exp_drop = 0;
    for (int i = 0; i < 300; i++) begin
      send6(3'd7, 16'(i), "oor");
      exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
      check("oor_drop", {24'b0, dc6}, 32'(exp_drop));
    end
    send6(3'd7, 16'hFFFF, "sat");
    check("sat_drop", {24'b0, dc6}, 32'd255);
    send6(3'd6, 16'hEEEE, "sel6");
    check("sel6_drop", {24'b0, dc6}, 32'd255);
    check("pow2_drop8", {24'b0, dc8}, 32'd0);
    v6 = 1'b1; sel6 = 3'd5; d6 = 16'h5555;
    @(negedge clk);
    check("c6_inrange_rdy", {31'b0, ir6}, 32'd1);
    @(posedge clk); #1;
    v6 = 1'b0;
    check("c6_inrange_ovalid", {26'b0, ov6}, 32'h20);
    check("c6_inrange_lane5", {16'b0, od6[5*W +: W]}, 32'h5555);

    // asynchronous reset between edges
    send8(1, 0, 16'h0101, 1, "rfill1");
    send8(4, 0, 16'h0404, 1, "rfill4");
    check("rfill_ovalid", {24'b0, ov8}, 32'h12);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ovalid", {24'b0, ov8}, 32'h0);
    check("arst_data", {31'b0, (od8 == '0)}, 32'd1);
    check("arst_drop6", {24'b0, dc6}, 32'h0);
    check("arst_ovalid6", {26'b0, ov6}, 32'h0);
    for (int k = 0; k < 8; k++) exp_q[k].delete();
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ovalid", {24'b0, ov8}, 32'h0);
    send8(4, 0, 16'h4444, 1, "post_rst_rdy");
    check("post_rst_ov", {24'b0, ov8}, 32'h10);
    check("post_rst_lane4", {16'b0, lane8(4)}, 32'h4444);
    or8 = 8'h10;
    idle(1);
    or8 = 8'h00;
    check("post_rst_drained", {24'b0, ov8}, 32'h0);

    // final report
    for (int k = 0; k < 8; k++) check($sformatf("leftover_ch%0d", k), 32'(exp_q[k].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
